fpu_issue_sched: RTL and testbench

//  Issue scheduler for the shared FPU. Arbitrates round-robin between NUM_REQ FP

---
 rtl/fpu_issue_sched.sv | 155 +++++++++++++++
 tb/tb_fpu_issue_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: round-robin issue scheduler for the shared FPU.
// Picks one eligible reservation station per cycle, reserves the writeback
// cycle of the issued op so no two ops ever complete together, and tracks
// the non-pipelined FDIV/FSQRT unit.
// Optional build macro FPU_SCHED_STALL_CNT_EN adds a saturating stall counter
// output stall_cnt_o.
// Op code map (5 bits): 0 FADD, 1 FSUB, 2 FMUL, 3 FDIV, 4 FSQRT, 5 FSGNJ,
// 6 FSGNJN, 7 FSGNJX, 8 FMIN, 9 FMAX, 10 FCVT, 11 FMADD, 12 FMSUB,
// 13 FNMADD, 14 FNMSUB, 15 FMV, 16 FCLASS, 17 FCMP; others use LAT_MISC.
module fpu_issue_sched #(
  parameter int NUM_REQ    = 2,
  parameter int WB_WIN     = 32,
  parameter int LAT_SHORT  = 2,
  parameter int LAT_ADD    = 4,
  parameter int LAT_MUL    = 5,
  parameter int LAT_FMA    = 6,
  parameter int LAT_DIV_SP = 12,
  parameter int LAT_DIV_DP = 19,
  parameter int LAT_MISC   = 2,
  localparam int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [5*NUM_REQ-1:0] req_op_i,
  input  logic [NUM_REQ-1:0]   req_is_double_i,
  output logic [NUM_REQ-1:0]   req_grant_o,
  input  logic                 fpu_ready_i,
  output logic                 fpu_valid_o,
  output logic [4:0]           fpu_op_o,
  output logic                 fpu_is_double_o,
  output logic [SEL_W-1:0]     fpu_sel_o,
  input  logic                 flush_i,
  output logic                 div_busy_o
`ifdef FPU_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt_o
`endif
);

  localparam int CW = $clog2(WB_WIN + 1);

  localparam logic [4:0] OP_FADD = 5'd0,  OP_FSUB = 5'd1,   OP_FMUL = 5'd2;
  localparam logic [4:0] OP_FDIV = 5'd3,  OP_FSQRT = 5'd4,  OP_FSGNJ = 5'd5;
  localparam logic [4:0] OP_FSGNJN = 5'd6, OP_FSGNJX = 5'd7, OP_FMIN = 5'd8;
  localparam logic [4:0] OP_FMAX = 5'd9,  OP_FCVT = 5'd10,  OP_FMADD = 5'd11;
  localparam logic [4:0] OP_FMSUB = 5'd12, OP_FNMADD = 5'd13, OP_FNMSUB = 5'd14;
  localparam logic [4:0] OP_FMV = 5'd15,  OP_FCLASS = 5'd16, OP_FCMP = 5'd17;

  function automatic int lat_of(input logic [4:0] op, input logic dbl);
    case (op)
      OP_FADD, OP_FSUB:                          lat_of = LAT_ADD;
      OP_FMUL:                                   lat_of = LAT_MUL;
      OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB:  lat_of = LAT_FMA;
      OP_FDIV, OP_FSQRT:                         lat_of = dbl ? LAT_DIV_DP : LAT_DIV_SP;
      OP_FSGNJ, OP_FSGNJN, OP_FSGNJX,
      OP_FMV, OP_FCLASS, OP_FCMP:                lat_of = LAT_SHORT;
      OP_FMIN, OP_FMAX, OP_FCVT:                 lat_of = LAT_MISC;
      default:                                   lat_of = LAT_MISC;
    endcase
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    is_div = (op == OP_FDIV) || (op == OP_FSQRT);
  endfunction

  // r_slot[k] = writeback port already claimed k cycles from now
  logic [WB_WIN:1]  r_slot;
  logic [WB_WIN:1]  w_slot_next;
  logic [CW-1:0]    r_div_cnt;
  logic [CW-1:0]    w_div_next;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [4:0]       w_op   [NUM_REQ];
  logic [CW-1:0]    w_lat  [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic             w_found;
  logic [SEL_W-1:0] w_win;

  // Per-requester decode and eligibility; reset suppresses every grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_op[gi]   = req_op_i[5*gi +: 5];
    assign w_lat[gi]  = CW'(lat_of(w_op[gi], req_is_double_i[gi]));
    assign w_elig[gi] = req_valid_i[gi] & fpu_ready_i & ~flush_i & ~rst &
                        ~r_slot[w_lat[gi]] &
                        (~is_div(w_op[gi]) | (r_div_cnt == '0));
  end

  // Round-robin pick: first eligible requester at or after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_elig[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = SEL_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // FPU issue port; everything reads zero when nothing is granted.
  always_comb begin
    req_grant_o     = '0;
    fpu_valid_o     = w_found;
    fpu_op_o        = '0;
    fpu_is_double_o = 1'b0;
    fpu_sel_o       = '0;
    if (w_found) begin
      req_grant_o     = NUM_REQ'(1) << w_win;
      fpu_op_o        = w_op[w_win];
      fpu_is_double_o = req_is_double_i[w_win];
      fpu_sel_o       = w_win;
    end
  end

  // Next reservation window and divider countdown. The granted op lands
  // L cycles after issue, i.e. L-1 cycles after the coming edge.
  always_comb begin
    w_slot_next = {1'b0, r_slot[WB_WIN:2]};
    if (w_found) w_slot_next[w_lat[w_win] - CW'(1)] = 1'b1;
    w_div_next = r_div_cnt;
    if (w_found && is_div(w_op[w_win])) w_div_next = w_lat[w_win];
    else if (r_div_cnt != '0)           w_div_next = r_div_cnt - CW'(1);
  end

  // State registers; flush does not clear in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot    <= '0;
      r_div_cnt <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_slot    <= w_slot_next;
      r_div_cnt <= w_div_next;
      if (w_found)
        r_rr_ptr <= (w_win == SEL_W'(NUM_REQ - 1)) ? '0 : w_win + SEL_W'(1);
    end
  end

  assign div_busy_o = (r_div_cnt != '0);

`ifdef FPU_SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where work was offered (and not flushed) but nothing issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall_cnt <= '0;
    else if ((|req_valid_i) && !flush_i && !w_found && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched (NUM_REQ=2, default latencies). A reference
// model tracks absolute writeback cycles and the divider free time; each
// cycle's expected outputs go into a scoreboard queue and are compared
// when the DUT outputs are sampled on the falling edge.
// Build with +define+FPU_SCHED_STALL_CNT_EN to also check stall_cnt_o.
module tb_fpu_issue_sched;

  localparam logic [4:0] FADD = 5'd0, FSUB = 5'd1, FMUL = 5'd2, FDIV = 5'd3;
  localparam logic [4:0] FSQRT = 5'd4, FSGNJ = 5'd5, FSGNJN = 5'd6, FSGNJX = 5'd7;
  localparam logic [4:0] FMIN = 5'd8, FMAX = 5'd9, FCVT = 5'd10, FMADD = 5'd11;
  localparam logic [4:0] FMSUB = 5'd12, FNMADD = 5'd13, FNMSUB = 5'd14;
  localparam logic [4:0] FMV = 5'd15, FCLASS = 5'd16, FCMP = 5'd17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [1:0] req_valid = '0;
  logic [9:0] req_op = '0;
  logic [1:0] req_dbl = '0;
  logic       fpu_ready = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] grant;
  logic       valid;
  logic [4:0] op_o;
  logic       dbl_o;
  logic [0:0] sel_o;
  logic       busy;
`ifdef FPU_SCHED_STALL_CNT_EN
  logic [15:0] stall;
`endif

  fpu_issue_sched dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_is_double_i(req_dbl),
    .req_grant_o(grant), .fpu_ready_i(fpu_ready), .fpu_valid_o(valid),
    .fpu_op_o(op_o), .fpu_is_double_o(dbl_o), .fpu_sel_o(sel_o),
    .flush_i(flush), .div_busy_o(busy)
`ifdef FPU_SCHED_STALL_CNT_EN
    , .stall_cnt_o(stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state, in absolute cycle numbers
  int m_rr = 0;
  bit wb_busy [4096];
  int cyc = 0;
  int div_start = 0;
  int div_free = 0;
  int m_stall = 0;

  typedef struct {
    logic [1:0]  g;
    logic [4:0]  op;
    logic        dbl;
    logic        sel;
    logic        busy;
    logic [15:0] st;
  } exp_t;
  exp_t sb[$];

  function automatic int lat(input logic [4:0] op, input logic dbl);
    if (op == FADD || op == FSUB) return 4;
    if (op == FMUL) return 5;
    if (op >= FMADD && op <= FNMSUB) return 6;
    if (op == FDIV || op == FSQRT) return dbl ? 19 : 12;
    return 2; // sign-inject/move/class/compare, min/max/convert, unknown
  endfunction

  function automatic bit isdiv(input logic [4:0] op);
    return (op == FDIV) || (op == FSQRT);
  endfunction

  // One cycle: drive inputs just after the rising edge, predict, compare on
  // the falling edge, then advance the model.
  task automatic step(input logic [1:0] v, input logic [4:0] o0, input logic d0,
                      input logic [4:0] o1, input logic d1, input logic rdy,
                      input logic fl, output logic [1:0] g_obs);
    exp_t e, x;
    int w, l;
    logic [4:0] ops [2];
    logic ds [2];
    bit el [2];
    req_valid = v; req_op = {o1, o0}; req_dbl = {d1, d0};
    fpu_ready = rdy; flush = fl;
    ops[0] = o0; ops[1] = o1; ds[0] = d0; ds[1] = d1;
    for (int r = 0; r < 2; r++) begin
      l = lat(ops[r], ds[r]);
      el[r] = v[r] && rdy && !fl && !wb_busy[cyc + l] && (!isdiv(ops[r]) || cyc >= div_free);
    end
    w = -1;
    if (el[m_rr]) w = m_rr;
    else if (el[1 - m_rr]) w = 1 - m_rr;
    e.g    = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
    e.op   = (w < 0) ? 5'd0 : ops[w];
    e.dbl  = (w < 0) ? 1'b0 : ds[w];
    e.sel  = (w == 1);
    e.busy = (cyc > div_start) && (cyc < div_free);
    e.st   = 16'(m_stall);
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk($sformatf("grant@%0d", cyc), 32'(grant), 32'(x.g));
    chk($sformatf("valid@%0d", cyc), 32'(valid), 32'(x.g != 0));
    chk($sformatf("op@%0d", cyc), 32'(op_o), 32'(x.op));
    chk($sformatf("dbl@%0d", cyc), 32'(dbl_o), 32'(x.dbl));
    chk($sformatf("sel@%0d", cyc), 32'(sel_o), 32'(x.sel));
    chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(x.busy));
`ifdef FPU_SCHED_STALL_CNT_EN
    chk($sformatf("stall@%0d", cyc), 32'(stall), 32'(x.st));
`endif
    g_obs = grant;
    if (w >= 0) begin
      l = lat(ops[w], ds[w]);
      wb_busy[cyc + l] = 1'b1;
      m_rr = 1 - w;
      if (isdiv(ops[w])) begin
        div_start = cyc;
        div_free  = cyc + l + 1; // counter holds l..1 on the next l cycles
      end
    end else if ((|v) && !fl && m_stall < 65535) begin
      m_stall++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    repeat (n) step(2'b00, FADD, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
  endtask

  // Assert reset with both requesters offering work; outputs must drop at once.
  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = 2'b11; req_op = {FADD, FADD}; req_dbl = 2'b00;
    fpu_ready = 1'b1; flush = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op", 32'(op_o), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hold_grant", 32'(grant), 32'd0);
`ifdef FPU_SCHED_STALL_CNT_EN
    chk("rst_stall", 32'(stall), 32'd0);
`endif
    rst = 1'b0;
    cyc += n;
    m_rr = 0;
    foreach (wb_busy[i]) wb_busy[i] = 1'b0;
    div_start = cyc;
    div_free  = cyc;
    m_stall   = 0;
    sb.delete();
  endtask

  logic [1:0] g;
  int sqrt_at;
  logic [4:0] op_tab [18];

  initial begin
    op_tab = '{FADD, FSUB, FMUL, FDIV, FSQRT, FSGNJ, FSGNJN, FSGNJX, FMIN,
               FMAX, FCVT, FMADD, FMSUB, FNMADD, FNMSUB, FMV, FCLASS, FCMP};
    #2;
    do_reset(2);

    // Two FADD streams alternate starting from requester 0
    for (int i = 0; i < 6; i++) begin
      step(2'b11, FADD, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
      chk($sformatf("t2_alt%0d", i), 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle(8);

    // FMUL then FADD from requester 0: FADD would land on the FMUL cycle
    step(2'b01, FMUL, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
    chk("t3_fmul", 32'(g), 32'd1);
    step(2'b01, FADD, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
    chk("t3_fadd_blk", 32'(g), 32'd0);
    step(2'b01, FADD, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
    chk("t3_fadd_ok", 32'(g), 32'd1);
    idle(8);

    // Double FDIV at t0: counter 19..1 on t1..t19, so FSQRT issues at t20.
    // Requester 0 offers FADD on odd cycles; t15 collides with the FDIV writeback.
    step(2'b01, FDIV, 1'b1, FSQRT, 1'b0, 1'b1, 1'b0, g);
    chk("t4_fdiv", 32'(g), 32'd1);
    sqrt_at = -1;
    for (int k = 1; k <= 22; k++) begin
      step({1'b1, 1'(k % 2)}, FADD, 1'b0, FSQRT, 1'b0, 1'b1, 1'b0, g);
      if (g[1] && sqrt_at < 0) sqrt_at = k;
      if (k == 15) chk("t4_fadd_wb_blk", 32'(g), 32'd0);
      if (k == 3)  chk("t4_fadd_pass", 32'(g), 32'd1);
    end
    chk("t4_sqrt_cycle", 32'(sqrt_at), 32'd20);
    idle(25);

    // Flush blocks issue but the earlier FMA keeps its writeback claimed
    step(2'b01, FMADD, 1'b0, FMADD, 1'b0, 1'b1, 1'b0, g);
    chk("t5_fma", 32'(g), 32'd1);
    step(2'b11, FMADD, 1'b0, FMADD, 1'b0, 1'b1, 1'b1, g);
    chk("t5_flush", 32'(g), 32'd0);
    step(2'b01, FADD, 1'b0, FMADD, 1'b0, 1'b1, 1'b0, g);
    chk("t5_conflict_blk", 32'(g), 32'd0);
    idle(8);

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 17)];
      b = ($urandom_range(0, 3) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 17)];
      step(2'($urandom_range(0, 3)), a, 1'($urandom), b, 1'($urandom),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) == 0), g);
    end
    idle(25);

    // Reset in the middle of a divide (counter at 7)
    step(2'b01, FDIV, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
    chk("t1_fdiv", 32'(g), 32'd1);
    idle(5);
    chk("t1_busy_pre", 32'(busy), 32'd1);
    do_reset(1);
    step(2'b11, FADD, 1'b0, FADD, 1'b0, 1'b1, 1'b0, g);
    chk("t1_rr0", 32'(g), 32'd1);

`ifdef FPU_SCHED_STALL_CNT_EN
    do_reset(1);
    repeat (3) step(2'b01, FADD, 1'b0, FADD, 1'b0, 1'b0, 1'b0, g);
    chk("t6_stall3", 32'(stall), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
